// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bit-count constants.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } state_t;

  localparam int         I2C_BITS     = 8;
  localparam logic [2:0] BIT_CNT_INIT = 3'(I2C_BITS - 1);

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk and produces registered edge, START and STOP events.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_hist;
  logic       sda_hist;

  // History value lines up with the registered events, so the FSM samples data aligned to them.
  assign sda_s = sda_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_hist  <= 1'b1;
      sda_hist  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[0], scl};
      sda_sync  <= {sda_sync[0], sda};
      scl_hist  <= scl_sync[1];
      sda_hist  <= sda_sync[1];
      scl_rise  <= scl_sync[1] & ~scl_hist;
      scl_fall  <= ~scl_sync[1] & scl_hist;
      start_det <= scl_sync[1] & scl_hist & ~sda_sync[1] & sda_hist;
      stop_det  <= scl_sync[1] & scl_hist & sda_sync[1] & ~sda_hist;
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a single 7-bit address; open-drain SDA, never stretches SCL.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy,
  output state_t     state_dbg
);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       sda_oe;
  logic       got_byte;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] shifted;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda       = sda_oe ? 1'b0 : 1'bz;
  assign state_dbg = state;
  assign shifted   = {shreg[6:0], sda_s};

  // got_byte marks "8th bit seen on scl_rise, act on the following scl_fall".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= BIT_CNT_INIT;
      shreg    <= 8'h00;
      sda_oe   <= 1'b0;
      got_byte <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= BIT_CNT_INIT;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        got_byte <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        got_byte <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end
          ADDR: begin
            if (scl_rise) begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                if (shifted[7:1] == SLAVE_ADDR) begin
                  rw       <= shifted[0];
                  got_byte <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end else if (scl_fall && got_byte) begin
              got_byte <= 1'b0;
              state    <= ADDR_ACK;
              sda_oe   <= 1'b1;
              busy     <= 1'b1;
              tx_req   <= rw;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= BIT_CNT_INIT;
              if (rw) begin
                shreg  <= tx_data;
                sda_oe <= ~tx_data[7];
                state  <= RD_BYTE;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_BYTE;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                rx_data  <= shifted;
                rx_valid <= 1'b1;
                got_byte <= 1'b1;
              end
            end else if (scl_fall && got_byte) begin
              got_byte <= 1'b0;
              sda_oe   <= 1'b1;
              state    <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_oe  <= ~shreg[6];
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                tx_req   <= 1'b1;
                got_byte <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else if (scl_fall && got_byte) begin
              got_byte <= 1'b0;
              shreg    <= tx_data;
              sda_oe   <= ~tx_data[7];
              bit_cnt  <= BIT_CNT_INIT;
              state    <= RD_BYTE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master, a table of single-byte writes,
// and hand-written sequences for reads, repeated START, reset and STOP mid-byte.
module tb_i2c_slave;
  import i2c_slave_pkg::*;

  localparam int Q = 12;  // clk cycles per quarter SCL period

  logic       clk;
  logic       reset_n;
  logic       scl;
  logic       m_low;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rw;
  logic       busy;
  state_t     state_dbg;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl       (scl),
    .sda       (sda_bus),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .rw        (rw),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_vec  = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic       prev_rx = 1'b0;
  logic       prev_tx = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors rx/tx pulses, scores rx_data, and answers tx_req from tx_q.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected no rx_valid at %0t", rx_data, $time);
        end else begin
          check("rx_data", {24'b0, rx_data}, {24'b0, exp_q.pop_front()});
        end
      end
      if (tx_req) begin
        tx_cnt++;
        tx_data = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hEE;
      end
      if (rx_valid || tx_req)
        check("pulse_rules",
              {30'b0, rx_valid & tx_req, (rx_valid & prev_rx) | (tx_req & prev_tx)}, 32'd0);
      prev_rx = rx_valid;
      prev_tx = tx_req;
    end
  end

  // ---------------- bus master driver tasks ----------------
  task automatic q_wait();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; q_wait();
    scl   = 1'b1; q_wait();
    m_low = 1'b1; q_wait();
    scl   = 1'b0; q_wait();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; q_wait();
    scl   = 1'b1; q_wait();
    m_low = 1'b0; q_wait();
    q_wait();
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; q_wait();
    scl   = 1'b1; q_wait();
    q_wait();
    scl   = 1'b0; q_wait();
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; q_wait();
    scl   = 1'b1; q_wait();
    @(negedge clk);
    b = sda_bus;
    q_wait();
    scl   = 1'b0; q_wait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data;
    logic       exp_nack;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         rx0;
    int         tx0;

    vecs[0] = '{8'h84, 8'hA5, 1'b0};  // 0x42 W
    vecs[1] = '{8'h86, 8'h11, 1'b1};  // 0x43 W, miss
    vecs[2] = '{8'h00, 8'h22, 1'b1};  // general call
    vecs[3] = '{8'h84, 8'h00, 1'b0};
    vecs[4] = '{8'h84, 8'hFF, 1'b0};
    vecs[5] = '{8'h04, 8'h33, 1'b1};  // 0x02
    vecs[6] = '{8'hFE, 8'h44, 1'b1};  // 0x7F
    vecs[7] = '{8'hC4, 8'h55, 1'b1};  // 0x62

    reset_n = 1'b0;
    scl     = 1'b1;
    m_low   = 1'b0;
    tx_data = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", {24'b0, rx_data}, 32'h00);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_tx_req", {31'b0, tx_req}, 32'd0);
    check("rst_rw", {31'b0, rw}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_sda", {31'b0, sda_bus}, 32'd1);
    reset_n = 1'b1;
    q_wait();

    // Table: single-byte write attempts, addressed or not.
    for (int v = 0; v < 8; v++) begin
      rx0 = rx_cnt;
      i2c_start();
      write_byte(vecs[v].addr_byte, ack);
      check($sformatf("vec%0d_addr_ack", v), {31'b0, ack}, {31'b0, vecs[v].exp_nack});
      check($sformatf("vec%0d_busy", v), {31'b0, busy}, {31'b0, ~vecs[v].exp_nack});
      if (!vecs[v].exp_nack) exp_q.push_back(vecs[v].data);
      write_byte(vecs[v].data, ack);
      check($sformatf("vec%0d_data_ack", v), {31'b0, ack}, {31'b0, vecs[v].exp_nack});
      i2c_stop();
      check($sformatf("vec%0d_rx_cnt", v), 32'(rx_cnt - rx0), vecs[v].exp_nack ? 32'd0 : 32'd1);
      check($sformatf("vec%0d_busy_end", v), {31'b0, busy}, 32'd0);
      check($sformatf("vec%0d_state_end", v), 32'(state_dbg), 32'(IDLE));
    end

    // Two-byte write.
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    check("wr_addr_ack", {31'b0, ack}, 32'd0);
    exp_q.push_back(8'hA5);
    write_byte(8'hA5, ack);
    check("wr_ack1", {31'b0, ack}, 32'd0);
    check("wr_busy", {31'b0, busy}, 32'd1);
    exp_q.push_back(8'h3C);
    write_byte(8'h3C, ack);
    check("wr_ack2", {31'b0, ack}, 32'd0);
    i2c_stop();
    check("wr_rx_cnt", 32'(rx_cnt - rx0), 32'd2);
    check("wr_rx_data", {24'b0, rx_data}, 32'h3C);
    check("wr_busy_end", {31'b0, busy}, 32'd0);

    // Read: two bytes, master ACKs then NACKs.
    tx0 = tx_cnt;
    tx_q.push_back(8'h81);
    tx_q.push_back(8'h7E);
    i2c_start();
    write_byte(8'h85, ack);
    check("rd_addr_ack", {31'b0, ack}, 32'd0);
    check("rd_rw", {31'b0, rw}, 32'd1);
    read_byte(rd, 1'b0);
    check("rd_byte1", {24'b0, rd}, 32'h81);
    read_byte(rd, 1'b1);
    check("rd_byte2", {24'b0, rd}, 32'h7E);
    check("rd_release", {31'b0, sda_bus}, 32'd1);
    check("rd_state_nack", 32'(state_dbg), 32'(IDLE));
    check("rd_busy_nack", {31'b0, busy}, 32'd0);
    check("rd_tx_cnt", 32'(tx_cnt - tx0), 32'd2);
    i2c_stop();

    // Repeated START: write 0x10 then switch to read.
    tx0 = tx_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    check("sr_wr_addr_ack", {31'b0, ack}, 32'd0);
    exp_q.push_back(8'h10);
    write_byte(8'h10, ack);
    check("sr_wr_ack", {31'b0, ack}, 32'd0);
    check("sr_rw_before", {31'b0, rw}, 32'd0);
    tx_q.push_back(8'hC3);
    i2c_start();
    write_byte(8'h85, ack);
    check("sr_rd_addr_ack", {31'b0, ack}, 32'd0);
    check("sr_rw_after", {31'b0, rw}, 32'd1);
    read_byte(rd, 1'b1);
    check("sr_rd_byte", {24'b0, rd}, 32'hC3);
    check("sr_rx_data", {24'b0, rx_data}, 32'h10);
    check("sr_tx_cnt", 32'(tx_cnt - tx0), 32'd1);
    i2c_stop();

    // Reset while the slave holds the address ACK low.
    tx_q.push_back(8'h99);
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(8'h85 >> i);
    m_low = 1'b0; q_wait();
    scl   = 1'b1; q_wait();
    @(negedge clk);
    check("rst_ack_driven", {31'b0, sda_bus}, 32'd0);
    check("rst_mid_busy_pre", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_sda", {31'b0, sda_bus}, 32'd1);
    check("rst_mid_rx_data", {24'b0, rx_data}, 32'h00);
    check("rst_mid_rw", {31'b0, rw}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_state", 32'(state_dbg), 32'(IDLE));
    q_wait();
    scl = 1'b0; q_wait();
    reset_n = 1'b1; q_wait();
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    check("post_rst_addr_ack", {31'b0, ack}, 32'd0);
    exp_q.push_back(8'h55);
    write_byte(8'h55, ack);
    check("post_rst_data_ack", {31'b0, ack}, 32'd0);
    i2c_stop();
    check("post_rst_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    check("post_rst_rx_data", {24'b0, rx_data}, 32'h55);

    // STOP after four data bits.
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    check("stop_mid_addr_ack", {31'b0, ack}, 32'd0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    i2c_stop();
    check("stop_mid_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
    check("stop_mid_state", 32'(state_dbg), 32'(IDLE));
    check("stop_mid_busy", {31'b0, busy}, 32'd0);
    check("stop_mid_sda", {31'b0, sda_bus}, 32'd1);

    q_wait();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errors);
    $finish;
  end

endmodule
